// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, typedefs and address-width helper for the register file
package rf_pkg;
  localparam int RF_DATA_W   = 24;
  localparam int RF_NUM_REGS = 16;
  function automatic int rf_clog2(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
  localparam int RF_ADDR_W = rf_clog2(RF_NUM_REGS);
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: range check, zero-reg mask, write bypass and busy flag for one read port
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] pend,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   data,
  output logic                busy
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
  logic valid;
  logic hit;
  // wr_en is already the effective write, so a hit only needs the address match
  always_comb begin
    valid = ({1'b0, addr} < LIMIT) && !(ZERO_REG != 0 && addr == '0);
    hit   = BYPASS != 0 && wr_en && wr_addr == addr;
    data  = !valid ? '0 : hit ? wr_data : regs[addr];
    busy  = valid && |(pend & (NUM_REGS'(1) << addr)) && !hit;
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with write bypass, optional zero register and pending-write scoreboard
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = rf_clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              PendSet,
  input  logic [ADDR_W-1:0] PendAddr,
  output logic              BusyRS,
  output logic              BusyRT
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                wr_eff;
  logic                pend_ok;
  // qualify write and pend-set; gating with Reset_n keeps the bypass silent during reset
  always_comb begin
    wr_eff   = Reset_n && RegWrite && ({1'b0, RD} < LIMIT) && !(ZERO_REG != 0 && RD == '0);
    pend_ok  = PendSet && ({1'b0, PendAddr} < LIMIT) && !(ZERO_REG != 0 && PendAddr == '0);
    clr_mask = wr_eff ? NUM_REGS'(1) << RD : '0;
    set_mask = pend_ok ? NUM_REGS'(1) << PendAddr : '0;
  end
  // register array write
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) regs <= '{default: '0};
    else if (wr_eff) regs[RD] <= WriteData;
  end
  // scoreboard: set is applied after clear so a newly issued producer wins
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) pend <= '0;
    else pend <= (pend & ~clr_mask) | set_mask;
  end
  rf_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_rs (
    .addr(RS), .regs(regs), .pend(pend), .wr_en(wr_eff), .wr_addr(RD), .wr_data(WriteData),
    .data(ReadRS), .busy(BusyRS)
  );
  rf_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_rt (
    .addr(RT), .regs(regs), .pend(pend), .wr_en(wr_eff), .wr_addr(RD), .wr_data(WriteData),
    .data(ReadRT), .busy(BusyRT)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for default, no-bypass and 12x32 register file configurations
module tb_reg_file_sb;
  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [3:0]  rs, rt, rd, pa;
  logic [31:0] wd;
  logic        we, ps;
  logic [23:0] a_rs, a_rt, b_rs, b_rt;
  logic [31:0] c_rs, c_rt;
  logic        a_brs, a_brt, b_brs, b_brt, c_brs, c_brt;
  int          n_vec = 0;
  int          n_bad = 0;
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t        sbq[$];
  logic [23:0] m_regs [16];
  logic        m_pend [16];
  logic        eff;

  always #5 Clock = ~Clock;

  reg_file_sb dut_a (
    .Clock(Clock), .Reset_n(Reset_n), .RS(rs), .RT(rt), .ReadRS(a_rs), .ReadRT(a_rt),
    .RD(rd), .WriteData(wd[23:0]), .RegWrite(we), .PendSet(ps), .PendAddr(pa),
    .BusyRS(a_brs), .BusyRT(a_brt)
  );
  reg_file_sb #(.BYPASS(0)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .RS(rs), .RT(rt), .ReadRS(b_rs), .ReadRT(b_rt),
    .RD(rd), .WriteData(wd[23:0]), .RegWrite(we), .PendSet(ps), .PendAddr(pa),
    .BusyRS(b_brs), .BusyRT(b_brt)
  );
  reg_file_sb #(.NUM_REGS(12), .DATA_W(32)) dut_c (
    .Clock(Clock), .Reset_n(Reset_n), .RS(rs), .RT(rt), .ReadRS(c_rs), .ReadRT(c_rt),
    .RD(rd), .WriteData(wd), .RegWrite(we), .PendSet(ps), .PendAddr(pa),
    .BusyRS(c_brs), .BusyRT(c_brt)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: return {8'h0, a_rs};
      1: return {8'h0, a_rt};
      2: return {31'h0, a_brs};
      3: return {31'h0, a_brt};
      4: return {8'h0, b_rs};
      5: return {31'h0, b_brs};
      6: return c_rs;
      7: return c_rt;
      8: return {31'h0, c_brs};
      9: return {8'h0, b_rt};
      default: return '1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic probe;
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic set(input logic w, input logic [3:0] d, input logic [31:0] x,
                     input logic p, input logic [3:0] a, input logic [3:0] s, input logic [3:0] t);
    we = w; rd = d; wd = x; ps = p; pa = a; rs = s; rt = t;
  endtask

  initial begin
    Reset_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0);
    tick;
    want("rst_rs", 0, 0); want("rst_brs", 2, 0); want("rst_nb", 4, 0); want("rst_p", 6, 0);
    probe;
    tick;
    Reset_n = 1'b1;
    // write r5, then asynchronous reset between edges clears it immediately
    set(1, 5, 32'h00ABCDEF, 0, 0, 5, 0);
    tick;
    set(0, 0, 0, 0, 0, 5, 0);
    want("r5", 0, 32'h00ABCDEF); want("p_r5", 6, 32'h00ABCDEF);
    probe;
    Reset_n = 1'b0;
    we = 1; rd = 5; wd = 32'h00111111;
    want("rst_async", 0, 0); want("rst_busy", 2, 0); want("rst_byp", 4, 0);
    probe;
    tick;
    Reset_n = 1'b1;
    we = 0;
    want("rst_lost", 0, 0);
    probe;
    // plain write/read and zero register
    set(1, 3, 32'h00123456, 0, 0, 0, 0);
    tick;
    set(0, 0, 0, 0, 0, 3, 3);
    want("r3_rs", 0, 32'h123456); want("r3_rt", 1, 32'h123456);
    probe;
    set(1, 0, 32'h00FFFFFF, 0, 0, 0, 0);
    tick;
    set(0, 0, 0, 0, 0, 0, 0);
    want("r0", 0, 0); want("p_r0", 6, 0);
    probe;
    // bypass versus no bypass
    set(1, 7, 32'h00111111, 0, 0, 0, 0);
    tick;
    set(1, 7, 32'h0000BEEF, 0, 0, 7, 0);
    want("byp", 0, 32'hBEEF); want("nobyp", 4, 32'h111111);
    probe;
    tick;
    set(0, 0, 0, 0, 0, 7, 0);
    want("byp_after", 0, 32'hBEEF); want("nobyp_after", 4, 32'hBEEF);
    probe;
    // scoreboard: double set, held busy, single retire
    set(0, 0, 0, 1, 9, 9, 9);
    tick;
    tick;
    set(0, 0, 0, 0, 0, 9, 9);
    for (int i = 0; i < 3; i++) begin
      want("busy9", 3, 1); want("nb_busy9", 5, 1);
      probe;
      tick;
    end
    set(1, 9, 32'h00999999, 0, 0, 9, 9);
    want("busy9_wb", 3, 0); want("nb_busy9_wb", 5, 1); want("byp9", 1, 32'h999999);
    want("nb_old9", 9, 0);
    probe;
    tick;
    set(0, 0, 0, 0, 0, 9, 9);
    want("busy9_clr", 3, 0); want("busy9_clr_rs", 2, 0); want("nb_busy9_clr", 5, 0);
    probe;
    // same-cycle set and retire: set wins
    set(1, 4, 32'h00444444, 1, 4, 4, 0);
    want("col_pre", 2, 0);
    probe;
    tick;
    set(0, 0, 0, 0, 0, 4, 0);
    want("col_busy", 2, 1); want("col_data", 0, 32'h444444);
    probe;
    // 12-register instance: out-of-range write/pend dropped, r11 full 32 bits
    set(1, 13, 32'hCAFEF00D, 1, 13, 0, 0);
    tick;
    set(1, 11, 32'hDEADBEEF, 0, 0, 13, 13);
    want("p_r13", 6, 0); want("p_b13", 8, 0); want("d_r13", 0, 32'hFEF00D); want("d_b13", 2, 1);
    probe;
    tick;
    set(0, 0, 0, 0, 0, 11, 13);
    want("p_r11", 6, 32'hDEADBEEF); want("p_rt13", 7, 0);
    probe;
    // random traffic against a reference model of the default instance
    Reset_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    tick;
    for (int k = 0; k < 300; k++) begin
      set(1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3) == 0,
          4'($urandom), 4'($urandom), 4'($urandom));
      eff = we && rd != 0;
      want("rnd_rs", 0, rs == 0 ? 32'h0 : (eff && rd == rs) ? {8'h0, wd[23:0]} : {8'h0, m_regs[rs]});
      want("rnd_rt", 1, rt == 0 ? 32'h0 : (eff && rd == rt) ? {8'h0, wd[23:0]} : {8'h0, m_regs[rt]});
      want("rnd_brs", 2, {31'h0, rs != 0 && m_pend[rs] && !(eff && rd == rs)});
      want("rnd_brt", 3, {31'h0, rt != 0 && m_pend[rt] && !(eff && rd == rt)});
      probe;
      if (eff) begin
        m_regs[rd] = wd[23:0];
        m_pend[rd] = 1'b0;
      end
      if (ps && pa != 0) m_pend[pa] = 1'b1;
      tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
